// File: rtl/pipe_issue.sv
// Issue stage for pipe_ex2: buffers packed instruction words in a FIFO, decodes them,
// and inserts bubbles on read-after-write hazards because the pipe does not forward.
module pipe_issue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HAZ_DEPTH   = 2,
    parameter int unsigned BUBBLE_REG  = 0,
    parameter int unsigned BUBBLE_ADDR = 255
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_instr,
    input  logic        hold,
    input  logic        flush,
    output logic [3:0]  rs1,
    output logic [3:0]  rs2,
    output logic [3:0]  rd,
    output logic [3:0]  func,
    output logic [7:0]  addr,
    output logic        issue_valid,
    output logic [15:0] stall_cnt
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned RW = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned IW = 24;
    localparam int unsigned SW = 16;

    localparam logic [RW-1:0] BUB_FUNC = RW'(3);
    localparam logic [RW-1:0] BUB_REG  = RW'(BUBBLE_REG);
    localparam logic [AW-1:0] BUB_ADDR = AW'(BUBBLE_ADDR);

    logic [IW-1:0]        mem [DEPTH];
    logic [PW-1:0]        wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]        rd_ptr, rd_ptr_nxt;
    logic [CW-1:0]        count, count_nxt;
    logic [HAZ_DEPTH-1:0] hist_v, hist_v_nxt;
    logic [RW-1:0]        hist_rd [HAZ_DEPTH];
    logic [RW-1:0]        hist_rd_nxt [HAZ_DEPTH];

    logic          push, pop, stall, hazard;
    logic [IW-1:0] head;
    logic [RW-1:0] rs1_nxt, rs2_nxt, rd_nxt, func_nxt;
    logic [AW-1:0] addr_nxt;
    logic          issue_valid_nxt;
    logic [SW-1:0] stall_cnt_nxt;

    assign in_ready = (count != CW'(DEPTH));
    assign head     = mem[rd_ptr];

    // Head word conflicts with the destination of any recently issued instruction.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < int'(HAZ_DEPTH); i++) begin
            if (hist_v[i] && ((hist_rd[i] == head[15:12]) || (hist_rd[i] == head[11:8]))) begin
                hazard = 1'b1;
            end
        end
    end

    always_comb begin
        push            = 1'b0;
        pop             = 1'b0;
        stall           = 1'b0;
        wr_ptr_nxt      = wr_ptr;
        rd_ptr_nxt      = rd_ptr;
        count_nxt       = count;
        hist_v_nxt      = hist_v;
        hist_rd_nxt     = hist_rd;
        stall_cnt_nxt   = stall_cnt;
        func_nxt        = BUB_FUNC;
        rd_nxt          = BUB_REG;
        rs1_nxt         = BUB_REG;
        rs2_nxt         = RW'(0);
        addr_nxt        = BUB_ADDR;
        issue_valid_nxt = 1'b0;

        if (flush) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
            hist_v_nxt = '0;
        end else begin
            push  = in_valid && in_ready;
            pop   = !hold && (count != '0) && !hazard;
            stall = !hold && (count != '0) && hazard;

            if (pop) begin
                {func_nxt, rd_nxt, rs1_nxt, rs2_nxt, addr_nxt} = head;
                issue_valid_nxt = 1'b1;
                rd_ptr_nxt      = rd_ptr + PW'(1);
            end
            if (push) begin
                wr_ptr_nxt = wr_ptr + PW'(1);
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt_nxt = stall_cnt + SW'(1);
            end
            count_nxt = count + CW'(push) - CW'(pop);

            // Age the issue history; bubbles enter as invalid slots.
            for (int i = int'(HAZ_DEPTH) - 1; i > 0; i--) begin
                hist_v_nxt[i]  = hist_v[i-1];
                hist_rd_nxt[i] = hist_rd[i-1];
            end
            hist_v_nxt[0]  = pop;
            hist_rd_nxt[0] = head[19:16];
        end
    end

    always_ff @(posedge clk1) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            hist_v      <= '0;
            for (int i = 0; i < int'(HAZ_DEPTH); i++) begin
                hist_rd[i] <= '0;
            end
            stall_cnt   <= '0;
            func        <= BUB_FUNC;
            rd          <= BUB_REG;
            rs1         <= BUB_REG;
            rs2         <= RW'(0);
            addr        <= BUB_ADDR;
            issue_valid <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
            count       <= count_nxt;
            hist_v      <= hist_v_nxt;
            hist_rd     <= hist_rd_nxt;
            stall_cnt   <= stall_cnt_nxt;
            func        <= func_nxt;
            rd          <= rd_nxt;
            rs1         <= rs1_nxt;
            rs2         <= rs2_nxt;
            addr        <= addr_nxt;
            issue_valid <= issue_valid_nxt;
        end
    end

endmodule
